// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared state/tag types and default widths for the screen RAM arbiter
package vram_arb_pkg;
   localparam int DEF_ADDR_W      = 15;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_MIN_VID_GAP = 4;
   typedef enum logic [1:0] {IDLE, VID_RD, CPU_RD, WB_WR} state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;
   function automatic tag_t tag_of(input state_t s);
      return (s == VID_RD) ? TAG_VID : (s == CPU_RD) ? TAG_CPU : TAG_NONE;
   endfunction
endpackage

// File: rtl/vram_wbuf.sv
// vram_wbuf: single-entry posted write buffer with address compare for read forwarding
module vram_wbuf
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_clk_sys,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic              i_drain,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic [ADDR_W-1:0] i_cmp_addr,
   output logic              o_valid,
   output logic              o_hit,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data
);
   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   // a load in the draining cycle refills the entry instead of emptying it
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_addr  <= i_addr;
         r_data  <= i_data;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end
   assign o_valid = r_valid;
   assign o_hit   = r_valid && (r_addr == i_cmp_addr);
   assign o_addr  = r_addr;
   assign o_data  = r_data;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port screen RAM arbiter; video fetches always win, CPU writes are posted
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MIN_VID_GAP = DEF_MIN_VID_GAP
) (
   input  logic              i_clk_sys,
   input  logic              i_reset,
   input  logic              i_vid_req,
   input  logic [ADDR_W-1:0] i_vid_addr,
   output logic [DATA_W-1:0] o_vid_dout,
   output logic              o_vid_valid,
   output logic              o_vid_err,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_din,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_dout,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_din,
   output logic              o_mem_we,
   input  logic [DATA_W-1:0] i_mem_dout
);
   localparam int               GAP_W   = $clog2(MIN_VID_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_VID_GAP);
   state_t            r_state, w_next;
   tag_t              r_tag_a, r_tag_b;
   logic [GAP_W-1:0]  r_gap;
   logic              r_cpu_busy, r_cpu_ack, r_vid_valid, r_vid_err, r_mem_we;
   logic [DATA_W-1:0] r_cpu_dout, r_vid_dout, r_mem_din;
   logic [ADDR_W-1:0] r_mem_addr, w_nx_addr, w_wb_addr;
   logic [DATA_W-1:0] w_wb_data;
   logic              w_wb_valid, w_wb_hit, w_wb_pend;
   logic              w_cpu_go, w_wr_acc, w_fwd, w_rd_iss, w_ret_vid, w_ret_cpu;
   vram_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
      .i_clk_sys (i_clk_sys),
      .i_reset   (i_reset),
      .i_load    (w_wr_acc),
      .i_drain   (r_state == WB_WR),
      .i_addr    (i_cpu_addr),
      .i_data    (i_cpu_din),
      .i_cmp_addr(i_cpu_addr),
      .o_valid   (w_wb_valid),
      .o_hit     (w_wb_hit),
      .o_addr    (w_wb_addr),
      .o_data    (w_wb_data)
   );
   // the buffer stays valid through its RAM write cycle so a read can still forward from it
   always_comb begin
      w_cpu_go  = i_cpu_req && !r_cpu_busy && !r_cpu_ack;
      w_wb_pend = w_wb_valid && (r_state != WB_WR);
      w_wr_acc  = w_cpu_go && i_cpu_we && (!w_wb_valid || r_state == WB_WR);
      w_fwd     = w_cpu_go && !i_cpu_we && w_wb_hit;
      w_rd_iss  = w_cpu_go && !i_cpu_we && !w_wb_valid && !i_vid_req;
      w_next    = i_vid_req ? VID_RD : w_wb_pend ? WB_WR : w_rd_iss ? CPU_RD : IDLE;
      w_nx_addr = i_vid_req ? i_vid_addr : w_wb_pend ? w_wb_addr : i_cpu_addr;
      w_ret_vid = r_tag_b == TAG_VID;
      w_ret_cpu = r_tag_b == TAG_CPU;
   end
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_tag_a     <= TAG_NONE;
         r_tag_b     <= TAG_NONE;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_mem_we    <= 1'b0;
         r_vid_dout  <= '0;
         r_vid_valid <= 1'b0;
         r_vid_err   <= 1'b0;
         r_gap       <= GAP_MAX;
         r_cpu_ack   <= 1'b0;
         r_cpu_dout  <= '0;
         r_cpu_busy  <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_tag_a     <= tag_of(w_next);
         r_tag_b     <= r_tag_a;
         r_mem_addr  <= (w_next == IDLE) ? r_mem_addr : w_nx_addr;
         r_mem_din   <= (w_next == WB_WR) ? w_wb_data : r_mem_din;
         r_mem_we    <= w_next == WB_WR;
         r_vid_dout  <= w_ret_vid ? i_mem_dout : r_vid_dout;
         r_vid_valid <= w_ret_vid;
         r_vid_err   <= r_vid_err || (i_vid_req && r_gap < GAP_MAX);
         r_gap       <= i_vid_req ? GAP_W'(1) : (r_gap == GAP_MAX) ? r_gap : r_gap + GAP_W'(1);
         // a read whose requester has already gone away finishes silently
         r_cpu_ack   <= w_wr_acc || w_fwd || (w_ret_cpu && i_cpu_req);
         r_cpu_dout  <= w_fwd ? w_wb_data : w_ret_cpu ? i_mem_dout : r_cpu_dout;
         r_cpu_busy  <= w_rd_iss || (r_cpu_busy && !w_ret_cpu);
      end
   end
   assign o_vid_dout  = r_vid_dout;
   assign o_vid_valid = r_vid_valid;
   assign o_vid_err   = r_vid_err;
   assign o_cpu_ack   = r_cpu_ack;
   assign o_cpu_dout  = r_cpu_dout;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_din   = r_mem_din;
   assign o_mem_we    = r_mem_we;
endmodule
